// File: rtl/wb_daq_channel_scheduler_pkg.sv
// Shared definitions for the DAQ channel scheduler: FSM encoding, bus word size
// and the burst-length normalisation helper.
package daq_sched_pkg;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t ST_IDLE    = 2'd0;
   localparam sched_state_t ST_ARB     = 2'd1;
   localparam sched_state_t ST_XFER    = 2'd2;
   localparam sched_state_t ST_RELEASE = 2'd3;

   localparam int DAQ_WORD_BYTES = 4;
   localparam int DAQ_MAX_BURST  = 16;

   // A programmed length of 0 (or anything past the maximum) means a full 16-word burst.
   function automatic logic [4:0] eff_burst(input logic [4:0] len);
      if (len == 5'd0 || len > 5'(DAQ_MAX_BURST))
         return 5'(DAQ_MAX_BURST);
      return len;
   endfunction

endpackage

// File: rtl/wb_daq_channel_scheduler_if.sv
// Channel-request / bus-master handshake bundle between the scheduler (master
// modport) and the channel blocks plus DAQ bus master (slave modport).
interface wb_daq_channel_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int AW     = 32,
   parameter int SEL_W  = $clog2(NUM_CH)
);

   logic [NUM_CH-1:0] request;
   logic [NUM_CH-1:0] fifo_empty;
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  select;
   logic              active;
   logic [AW-1:0]     address;
   logic              data_done;
   logic              bus_err;

   modport master (
      input  request, fifo_empty, data_done, bus_err,
      output grant, select, active, address
   );

   modport slave (
      output request, fifo_empty, data_done, bus_err,
      input  grant, select, active, address
   );

endinterface

// File: rtl/wb_daq_channel_scheduler_rr_picker.sv
// Combinational round-robin picker: first requester strictly after rr_ptr,
// wrapping, so the channel granted last has lowest priority next time.
module daq_rr_picker #(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] request,
   input  logic [SEL_W-1:0]  rr_ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  index,
   output logic              valid
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      grant = '0;
      index = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
         if (!valid && request[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/wb_daq_channel_scheduler.sv
// Wishbone DAQ channel scheduler: round-robin bus-master arbitration with bounded
// bursts, per-channel circular SRAM write pointers and wrap/timeout/error flags.
module wb_daq_channel_scheduler
   import daq_sched_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int AW        = 32,
   parameter int LEN_W     = 16,
   parameter int TIMEOUT_W = 8
) (
   input  logic                    wb_clk,
   input  logic                    wb_rst,
   input  logic                    enable,
   input  logic [NUM_CH*AW-1:0]    base_addr,
   input  logic [NUM_CH*LEN_W-1:0] buf_words,
   input  logic [4:0]              burst_len,
   input  logic [NUM_CH-1:0]       irq_clear,
   wb_daq_channel_scheduler_if.master bus,
   output logic [NUM_CH-1:0]       wrap_irq,
   output logic                    timeout,
   output logic                    err
);

   localparam int SEL_W = $clog2(NUM_CH);

   sched_state_t         state, state_nx;
   logic                 enable_q;
   logic [SEL_W-1:0]     rr_ptr;
   logic [SEL_W-1:0]     sel;
   logic [NUM_CH-1:0]    grant_r;
   logic                 active_r;
   logic [4:0]           word_cnt;
   logic [TIMEOUT_W-1:0] wdog;
   logic [LEN_W-1:0]     off [NUM_CH];

   logic [NUM_CH-1:0]    pick_grant;
   logic [SEL_W-1:0]     pick_idx;
   logic                 pick_valid;

   logic                 enable_rise;
   logic                 in_xfer;
   logic                 word_done;
   logic [AW-1:0]        sel_base;
   logic [LEN_W-1:0]     sel_buf;
   logic [LEN_W-1:0]     sel_off;
   logic [LEN_W:0]       off_inc;
   logic [LEN_W:0]       buf_lim;
   logic                 wrap_hit;
   logic                 wdog_sat;
   logic                 burst_end;
   logic                 xfer_exit;

   daq_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
      .request (bus.request),
      .rr_ptr  (rr_ptr),
      .grant   (pick_grant),
      .index   (pick_idx),
      .valid   (pick_valid)
   );

   assign enable_rise = enable & ~enable_q;
   assign in_xfer     = (state == ST_XFER);
   assign word_done   = in_xfer & bus.data_done;

   assign sel_base = base_addr[int'(sel)*AW +: AW];
   assign sel_buf  = buf_words[int'(sel)*LEN_W +: LEN_W];
   assign sel_off  = off[sel];

   // Zero-length buffer means the full 2^LEN_W words, hence the extra compare bit.
   assign off_inc  = {1'b0, sel_off} + (LEN_W+1)'(1);
   assign buf_lim  = (sel_buf == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, sel_buf};
   assign wrap_hit = word_done && (off_inc == buf_lim);

   assign wdog_sat  = in_xfer && !bus.data_done && (&wdog);
   assign burst_end = word_done && ((word_cnt + 5'd1) == eff_burst(burst_len));
   assign xfer_exit = burst_end || (word_done && bus.fifo_empty[sel]) ||
                      !enable || bus.bus_err || wdog_sat;

   assign bus.grant   = grant_r;
   assign bus.select  = sel;
   assign bus.active  = active_r;
   assign bus.address = in_xfer ? sel_base + AW'(sel_off) * AW'(DAQ_WORD_BYTES) : '0;

   always_comb begin
      // NOTE: state_nx gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_nx = state;
      case (state)
         ST_IDLE:    if (enable && |bus.request) state_nx = ST_ARB;
         ST_ARB:     state_nx = pick_valid ? ST_XFER : ST_IDLE;
         ST_XFER:    if (xfer_exit) state_nx = ST_RELEASE;
         ST_RELEASE: state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // NOTE: all registers below use non-blocking assignment so every read sees the
   // pre-edge value regardless of statement order within the block.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state    <= ST_IDLE;
         enable_q <= 1'b0;
         rr_ptr   <= SEL_W'(NUM_CH - 1);
         sel      <= '0;
         grant_r  <= '0;
         active_r <= 1'b0;
         word_cnt <= '0;
         wdog     <= '0;
         timeout  <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         enable_q <= enable;

         if (state == ST_ARB && pick_valid) begin
            grant_r  <= pick_grant;
            sel      <= pick_idx;
            active_r <= 1'b1;
            word_cnt <= '0;
            wdog     <= '0;
         end

         if (in_xfer) begin
            wdog <= bus.data_done ? '0 : wdog + TIMEOUT_W'(1);
            if (bus.data_done)
               word_cnt <= word_cnt + 5'd1;
            if (xfer_exit) begin
               grant_r  <= '0;
               active_r <= 1'b0;
            end
         end

         if (state == ST_RELEASE) begin
            rr_ptr   <= sel;
            word_cnt <= '0;
         end

         // Sticky flags: a re-enable clears them, but a same-cycle event still wins.
         if (enable_rise) begin
            timeout <= 1'b0;
            err     <= 1'b0;
         end
         if (wdog_sat)
            timeout <= 1'b1;
         if (bus.bus_err)
            err <= 1'b1;
      end
   end

   // NOTE: the offset array is deliberately reset; a burst after reset must start
   // at base_addr, so these cannot be left as uninitialised storage.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         for (int i = 0; i < NUM_CH; i++)
            off[i] <= '0;
         wrap_irq <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (enable_rise)
               off[i] <= '0;
            else if (word_done && sel == SEL_W'(i))
               off[i] <= wrap_hit ? '0 : off[i] + LEN_W'(1);
            wrap_irq[i] <= (wrap_hit && sel == SEL_W'(i)) | (wrap_irq[i] & ~irq_clear[i]);
         end
      end
   end

endmodule

// File: tb/tb_wb_daq_channel_scheduler.sv
// Scenario-driven bench for wb_daq_channel_scheduler: expected addresses and grant
// patterns are queued as stimulus is applied and popped when the DUT responds.
module tb_wb_daq_channel_scheduler;

   localparam int NUM_CH    = 4;
   localparam int AW        = 32;
   localparam int LEN_W     = 16;
   localparam int TIMEOUT_W = 8;

   logic                    wb_clk = 1'b0;
   logic                    wb_rst;
   logic                    enable;
   logic [NUM_CH*AW-1:0]    base_addr;
   logic [NUM_CH*LEN_W-1:0] buf_words;
   logic [4:0]              burst_len;
   logic [NUM_CH-1:0]       irq_clear;
   logic [NUM_CH-1:0]       wrap_irq;
   logic                    timeout;
   logic                    err;

   wb_daq_channel_scheduler_if #(.NUM_CH(NUM_CH), .AW(AW)) bus ();

   wb_daq_channel_scheduler #(
      .NUM_CH(NUM_CH), .AW(AW), .LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .enable    (enable),
      .base_addr (base_addr),
      .buf_words (buf_words),
      .burst_len (burst_len),
      .irq_clear (irq_clear),
      .bus       (bus),
      .wrap_irq  (wrap_irq),
      .timeout   (timeout),
      .err       (err)
   );

   always #5 wb_clk = ~wb_clk;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0]     exp_addr_q  [$];
   logic [NUM_CH-1:0] exp_grant_q [$];

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic word();
      bus.data_done = 1'b1;
      tick();
      bus.data_done = 1'b0;
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (bus.grant == '0 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (bus.grant === '0) begin
         errors++;
         $display("FAIL %s wait_grant: grant=%b after %0d cycles, required nonzero", tag, bus.grant, n);
      end
   endtask

   task automatic restart();
      bus.request = '0;
      enable      = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      tick();
   endtask

   task automatic apply_reset();
      wb_rst = 1'b1;
      tick();
      wb_rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [AW-1:0] exp_a;
      tick();
      checks++;
      if ({bus.grant, bus.active, bus.address, bus.select, wrap_irq, timeout, err} !== '0) begin
         errors++;
         $display("FAIL reset_state: grant=%b active=%b address=%h select=%0d wrap_irq=%b timeout=%b err=%b, required all 0",
                  bus.grant, bus.active, bus.address, bus.select, wrap_irq, timeout, err);
      end
      wb_rst = 1'b0;
      tick();
      burst_len   = 5'd4;
      bus.request = 4'b0001;
      wait_grant("reset_pre");
      word();
      word();
      wb_rst = 1'b1;
      tick();
      checks++;
      if ({bus.grant, bus.active, bus.address, bus.select} !== '0) begin
         errors++;
         $display("FAIL reset_mid_xfer: grant=%b active=%b address=%h select=%0d, required all 0",
                  bus.grant, bus.active, bus.address, bus.select);
      end
      wb_rst = 1'b0;
      exp_addr_q.push_back(32'h0000_1000);
      wait_grant("reset_post");
      exp_a = exp_addr_q.pop_front();
      checks++;
      if (bus.address !== exp_a) begin
         errors++;
         $display("FAIL reset_restart_addr: address=%h, required %h", bus.address, exp_a);
      end
      restart();
   endtask

   task automatic test_single_ch0();
      logic [AW-1:0] exp_a;
      burst_len   = 5'd4;
      bus.request = 4'b0001;
      tick();
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++;
         $display("FAIL ch0_grant_latency1: grant=%b, required 0000", bus.grant);
      end
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.active !== 1'b1) begin
         errors++;
         $display("FAIL ch0_grant_latency2: grant=%b active=%b, required 0001/1", bus.grant, bus.active);
      end
      for (int k = 0; k < 4; k++)
         exp_addr_q.push_back(32'h0000_1000 + 32'(4 * k));
      for (int k = 0; k < 4; k++) begin
         exp_a = exp_addr_q.pop_front();
         checks++;
         if (bus.address !== exp_a || bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL ch0_word%0d: address=%h grant=%b, required %h/0001", k, bus.address, bus.grant, exp_a);
         end
         word();
      end
      checks++;
      if (bus.grant !== 4'b0000 || bus.active !== 1'b0) begin
         errors++;
         $display("FAIL ch0_release: grant=%b active=%b, required 0000/0", bus.grant, bus.active);
      end
      exp_addr_q.push_back(32'h0000_1010);
      wait_grant("ch0_second");
      exp_a = exp_addr_q.pop_front();
      checks++;
      if (bus.address !== exp_a) begin
         errors++;
         $display("FAIL ch0_second_addr: address=%h, required %h", bus.address, exp_a);
      end
      restart();
   endtask

   task automatic test_round_robin();
      logic [NUM_CH-1:0] exp_g;
      apply_reset();
      burst_len   = 5'd1;
      bus.request = 4'b1111;
      exp_grant_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int k = 0; k < 5; k++) begin
         wait_grant("rr");
         exp_g = exp_grant_q.pop_front();
         checks++;
         if (bus.grant !== exp_g || bus.select !== 2'(k % NUM_CH)) begin
            errors++;
            $display("FAIL rr_grant%0d: grant=%b select=%0d, required %b/%0d", k, bus.grant, bus.select, exp_g, k % NUM_CH);
         end
         word();
         checks++;
         if (bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL rr_release%0d: grant=%b, required 0000", k, bus.grant);
         end
      end
      restart();
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a;
      burst_len   = 5'd8;
      bus.request = 4'b0100;
      exp_addr_q  = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2000, 32'h0000_2004};
      wait_grant("wrap");
      checks++;
      if (bus.grant !== 4'b0100) begin
         errors++;
         $display("FAIL wrap_grant: grant=%b, required 0100", bus.grant);
      end
      for (int k = 0; k < 3; k++) begin
         exp_a = exp_addr_q.pop_front();
         checks++;
         if (bus.address !== exp_a) begin
            errors++;
            $display("FAIL wrap_word%0d: address=%h, required %h", k, bus.address, exp_a);
         end
         word();
         checks++;
         if (wrap_irq !== ((k == 0) ? 4'b0000 : 4'b0100)) begin
            errors++;
            $display("FAIL wrap_irq_after_word%0d: wrap_irq=%b, required %b", k, wrap_irq, (k == 0) ? 4'b0000 : 4'b0100);
         end
      end
      exp_a = exp_addr_q.pop_front();
      checks++;
      if (bus.address !== exp_a) begin
         errors++;
         $display("FAIL wrap_word3: address=%h, required %h", bus.address, exp_a);
      end
      irq_clear     = 4'b0100;
      bus.data_done = 1'b1;
      tick();
      irq_clear     = '0;
      bus.data_done = 1'b0;
      checks++;
      if (wrap_irq !== 4'b0100) begin
         errors++;
         $display("FAIL wrap_set_over_clear: wrap_irq=%b, required 0100", wrap_irq);
      end
      irq_clear = 4'b0100;
      tick();
      irq_clear = '0;
      checks++;
      if (wrap_irq !== 4'b0000) begin
         errors++;
         $display("FAIL wrap_clear: wrap_irq=%b, required 0000", wrap_irq);
      end
      restart();
   endtask

   task automatic test_fifo_empty();
      logic [AW-1:0] exp_a;
      burst_len   = 5'd8;
      bus.request = 4'b0001;
      exp_addr_q  = '{32'h0000_1000, 32'h0000_1004};
      wait_grant("fifo");
      for (int k = 0; k < 2; k++) begin
         exp_a = exp_addr_q.pop_front();
         checks++;
         if (bus.address !== exp_a) begin
            errors++;
            $display("FAIL fifo_word%0d: address=%h, required %h", k, bus.address, exp_a);
         end
         bus.fifo_empty = (k == 1) ? 4'b0001 : 4'b0000;
         word();
         bus.fifo_empty = '0;
      end
      checks++;
      if (bus.grant !== 4'b0000) begin
         errors++;
         $display("FAIL fifo_release: grant=%b, required 0000", bus.grant);
      end
      exp_addr_q.push_back(32'h0000_1008);
      wait_grant("fifo_next");
      exp_a = exp_addr_q.pop_front();
      checks++;
      if (bus.address !== exp_a) begin
         errors++;
         $display("FAIL fifo_offset: address=%h, required %h", bus.address, exp_a);
      end
      restart();
   endtask

   task automatic test_timeout_err();
      int cnt = 0;
      burst_len   = 5'd4;
      bus.request = 4'b0010;
      wait_grant("timeout");
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: timeout=%b, required 0", timeout);
      end
      while (bus.grant != '0 && cnt < 400) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt != (1 << TIMEOUT_W) || timeout !== 1'b1 || bus.active !== 1'b0) begin
         errors++;
         $display("FAIL timeout_expiry: grant_cycles=%0d timeout=%b active=%b, required %0d/1/0",
                  cnt, timeout, bus.active, 1 << TIMEOUT_W);
      end
      wait_grant("bus_err");
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_early: err=%b, required 0", err);
      end
      bus.bus_err = 1'b1;
      tick();
      bus.bus_err = 1'b0;
      checks++;
      if (bus.grant !== 4'b0000 || err !== 1'b1) begin
         errors++;
         $display("FAIL bus_err_release: grant=%b err=%b, required 0000/1", bus.grant, err);
      end
      restart();
      checks++;
      if (err !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear_on_enable: err=%b timeout=%b, required 0/0", err, timeout);
      end
   endtask

   initial begin
      wb_rst         = 1'b1;
      enable         = 1'b1;
      burst_len      = 5'd4;
      irq_clear      = '0;
      bus.request    = '0;
      bus.fifo_empty = '0;
      bus.data_done  = 1'b0;
      bus.bus_err    = 1'b0;
      base_addr      = {32'h0000_4000, 32'h0000_2000, 32'h0000_3000, 32'h0000_1000};
      buf_words      = {16'd64, 16'd2, 16'd64, 16'd64};

      test_reset();
      test_single_ch0();
      test_round_robin();
      test_wrap();
      test_fifo_empty();
      test_timeout_err();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
